// File: rtl/iterative_shifter_param_pkg.sv
// Shared definitions for the iterative shifter: mode codes, FSM states and
// the reserved-mode test used by both the top level and the step datapath.
package shifter_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Codes above ROR are reserved and treated as a pass-through.
  function automatic logic is_reserved_mode(input logic [2:0] mode);
    return mode > MODE_ROR;
  endfunction

endpackage

// File: rtl/iterative_shifter_param_shift_step.sv
// One iteration of the shifter: shifts or rotates the working value by k
// positions (0..STEP) in the selected mode. Purely combinational.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] doubled;
  logic [2*WIDTH-1:0] rol_wide;
  logic [2*WIDTH-1:0] ror_wide;

  // Rotates are taken from a doubled copy of the operand so wrapped bits
  // fall naturally into the kept half; k=0 leaves the value untouched.
  always_comb begin
    doubled  = {data, data};
    rol_wide = doubled << k;
    ror_wide = doubled >> k;
    result   = data;
    case (mode)
      MODE_SLL: result = data << k;
      MODE_SRL: result = data >> k;
      MODE_SRA: result = $unsigned($signed(data) >>> k);
      MODE_ROL: result = rol_wide[2*WIDTH-1:WIDTH];
      MODE_ROR: result = ror_wide[WIDTH-1:0];
      default:  result = data;
    endcase
  end

endmodule

// File: rtl/iterative_shifter_param.sv
// Multi-cycle shifter: moves up to STEP bit positions per clock with
// valid/ready handshakes on both sides and a synchronous abort.
module iterative_shifter_param
  import shifter_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  STEP    = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_mode,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int K_W = $clog2(STEP + 1);

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] count_after;
  logic [WIDTH-1:0]   work_reg;
  logic [2:0]         mode_reg;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   step_result;
  logic               accept;
  logic               direct_done;

  // Abort in IDLE wins over a pending request.
  assign accept      = in_valid && (state == ST_IDLE) && !abort;
  // Zero shifts and reserved modes skip SHIFT and return the operand as-is.
  assign direct_done = (in_shamt == '0) || is_reserved_mode(in_mode);

  // Step size this cycle: whatever is left, capped at STEP.
  always_comb begin
    k = '0;
    if ({1'b0, count} < (SHAMT_W + 1)'(STEP)) begin
      k = K_W'(count);
    end else begin
      k = K_W'(STEP);
    end
    count_after = count - SHAMT_W'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .data   (work_reg),
    .k      (k),
    .mode   (mode_reg),
    .result (step_result)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE holds under backpressure until out_ready or abort.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = direct_done ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (count_after == '0) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort || out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded straight from the state.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state != ST_IDLE);
  end

  // Datapath: latch the request, iterate, and capture the final value into
  // out_data only when an operation completes so it stays put afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_reg <= '0;
      count    <= '0;
      mode_reg <= MODE_SLL;
      out_data <= '0;
    end else if (accept) begin
      work_reg <= in_data;
      count    <= in_shamt;
      mode_reg <= in_mode;
      if (direct_done) begin
        out_data <= in_data;
      end
    end else if ((state == ST_SHIFT) && !abort) begin
      work_reg <= step_result;
      count    <= count_after;
      if (count_after == '0) begin
        out_data <= step_result;
      end
    end
  end

endmodule

// File: doc/iterative_shifter_param.md
Name: iterative_shifter_param

Overview:
- Multi-cycle barrel-free shifter for the SoC datapath utilities. Shifts up to STEP bit positions per clock, trading area against latency.
- Generalises the existing single-bit iterative shifter:
  - parametrised data width and per-cycle step;
  - adds rotate modes;
  - uses valid/ready handshakes on input and output instead of a start pulse and done flag;
  - supports abort.
- Used by the CPU shift unit and the neuromorphic accelerator's weight/potential scaling path.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8 to 64.
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 to WIDTH.
- SHAMT_W, $clog2(WIDTH), width of shift amount (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHAMT_W  shift amount, 0 to WIDTH-1.
- in_mode  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved.
- abort  in  1  synchronous cancel of the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset state (asserted asynchronously, held while rst high):
  - state IDLE, out_valid 0, out_data 0, busy 0, in_ready 1;
  - internal count 0, working register 0, latched mode 000.
- Three states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE), combinational from state.
  - out_valid = (state==DONE).
  - busy = (state!=IDLE).
- IDLE: on in_valid && in_ready at edge T0:
  - latch in_data into the working register, in_shamt into count, in_mode into the mode register;
  - go to SHIFT if in_shamt!=0 and mode is not reserved, otherwise go to DONE.
- SHIFT: each edge shifts the working register by k = min(count, STEP) in the latched mode, and count <= count-k.
  - When the post-update count is 0, go to DONE.
  - Cycles in SHIFT: N = ceil(shamt/STEP). out_valid rises after edge T0+N; for shamt=0 it rises after T0.
- Mode semantics per step:
  - SLL/SRL: zero fill.
  - SRA: replicate the MSB of the working register.
  - ROL/ROR: bits wrap modulo WIDTH.
  - Reserved modes: pass-through, out_data = in_data, 1-cycle latency.
- DONE: out_data holds the final value, stable while out_valid && !out_ready. No change of out_data or state under backpressure.
  - On out_ready go to IDLE; out_data retains its last value.
  - No new request is accepted in the same cycle as the output handshake (in_ready is low in DONE).
- abort: sampled at every edge.
  - In SHIFT or DONE: go to IDLE; the result is discarded and out_valid drops the next cycle.
  - In IDLE: abort has priority over acceptance; the request is not taken, and in_ready stays high.
- Reset mid-operation: the result is lost and the block is immediately in IDLE; no spurious out_valid.
- Shift amount >= WIDTH is impossible by width.
- Count width is SHAMT_W; no wrap occurs because k <= count.

Decomposition:
- Package shifter_pkg holds:
  - mode constants MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL, MODE_ROR;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE;
  - a function is_reserved_mode.
- Sub-module shift_step: combinational. Inputs are the data, k (0..STEP), and mode. Output is data shifted or rotated by k. It is instantiated once and fed from the working register.

Test Plan:
- WIDTH=32, STEP=4: SLL 0x0000_0001 by 31 -> out_valid after 8 shift cycles, out_data 0x8000_0000, busy high throughout.
- SRA 0x8000_0000 by 4 -> 1 shift cycle, out_data 0xF800_0000. SRL of the same operand -> 0x0800_0000.
- ROR 0x1234_5678 by 8 -> 0x7812_3456 after 2 cycles. ROL 0x8000_0001 by 1 -> 0x0000_0003.
- shamt 0 (SLL 0xDEAD_BEEF) -> out_valid the cycle after accept, out_data 0xDEAD_BEEF.
- Reserved mode 111 with 0xA5A5_A5A5 -> pass-through after 1 cycle.
- Backpressure: out_ready low for 5 cycles -> out_data and out_valid stable, in_ready low, second in_valid ignored. out_ready high -> IDLE next cycle.
- Abort at SHIFT cycle 3 of a 31-bit SLL -> out_valid never asserts, in_ready high the next cycle.
- rst pulse mid-SHIFT (asynchronous, between edges) -> outputs go to reset values immediately, next request behaves normally.
- Repeat all scenarios with STEP=1 and STEP=32 to confirm the latencies ceil(shamt/STEP).
